// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the direct-mapped instruction cache.
//   state_t  : controller FSM states (IDLE, REFILL, RESP)
//   off_w    : word-offset width for a line size
//   idx_w    : line-index width for an array depth and line size
//   addr_t   : {tag, index, offset, byte} split of a fetch address at the default geometry
package icache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    localparam int DEPTH_DEF      = 128;
    localparam int LINE_WORDS_DEF = 4;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int depth, input int line_words);
        return $clog2(depth / line_words);
    endfunction

    localparam int OFF_W = off_w(LINE_WORDS_DEF);
    localparam int IDX_W = idx_w(DEPTH_DEF, LINE_WORDS_DEF);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
        logic [1:0]       byte_off;
    } addr_t;

endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: DEPTH x 32 instruction data array, combinational read, synchronous write.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address
//   rdata_o : read data (combinational)
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller with whole-line linear refill.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   if_req_i, if_pc_i       : fetch request and byte address
//   if_ready_o              : request can be accepted this cycle
//   if_valid_o, if_ins_o    : one-cycle response pulse and instruction
//   flush_i                 : invalidate all lines
//   mem_req_o, mem_addr_o   : refill beat request and word-aligned address
//   mem_ack_i, mem_rdata_i  : beat accepted with its data
//   hit_cnt_o, miss_cnt_o   : accepted hit/miss counters, only with ICACHE_STATS_EN defined
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ready_o,
    output logic        if_valid_o,
    output logic [31:0] if_ins_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int OW    = off_w(LINE_WORDS);
    localparam int IW    = idx_w(DEPTH, LINE_WORDS);
    localparam int TW    = 30 - OW - IW;
    localparam int AW    = OW + IW;
    localparam int LINES = DEPTH / LINE_WORDS;

    state_t           state_q, state_d;
    logic [OW-1:0]    beat_q, beat_d;
    logic [29:0]      pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      if_ins_q, if_ins_d;
    logic [TW-1:0]    tags_q [LINES];
    logic             tag_we;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx, line_idx;
    logic          accept, hit, ram_we, unused_pc;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_rdata;

    assign unused_pc  = ^if_pc_i[1:0];
    assign req_idx    = if_pc_i[2+OW +: IW];
    assign req_tag    = if_pc_i[31 -: TW];
    assign line_idx   = pc_q[OW +: IW];
    assign if_ready_o = (state_q == IDLE) && !flush_i;
    assign accept     = if_req_i && if_ready_o;
    assign hit        = valid_q[req_idx] && (tags_q[req_idx] == req_tag);
    assign mem_req_o  = (state_q == REFILL);
    assign mem_addr_o = mem_req_o ? {pc_q[29:OW], beat_q, 2'b00} : 32'h0;
    assign ram_we     = mem_req_o && mem_ack_i;
    assign ram_waddr  = {line_idx, beat_q};
    // RESP replays the captured pc so the response comes from the freshly filled line.
    assign ram_raddr  = (state_q == RESP) ? pc_q[AW-1:0] : if_pc_i[2 +: AW];
    assign if_valid_o = if_valid_q;
    assign if_ins_o   = if_ins_q;

    icache_data_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (mem_rdata_i),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        if_valid_d = 1'b0;
        if_ins_d   = if_ins_q;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pc_d = if_pc_i[31:2];
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_ins_d   = ram_rdata;
                    end else begin
                        // The line's data is about to be overwritten, so it must not hit meanwhile.
                        valid_d[req_idx] = 1'b0;
                        state_d          = REFILL;
                        beat_d           = '0;
                        pend_d           = 1'b0;
                    end
                end
            end
            REFILL: begin
                if (flush_i) pend_d = 1'b1;
                if (mem_ack_i) begin
                    beat_d = beat_q + OW'(1);
                    if (&beat_q) state_d = RESP;
                end
            end
            RESP: begin
                tag_we            = 1'b1;
                valid_d[line_idx] = !pend_q && !flush_i;
                if_valid_d        = 1'b1;
                if_ins_d          = ram_rdata;
                pend_d            = 1'b0;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            pc_q       <= '0;
            pend_q     <= 1'b0;
            valid_q    <= '0;
            if_valid_q <= 1'b0;
            if_ins_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            if_valid_q <= if_valid_d;
            if_ins_q   <= if_ins_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we) tags_q[line_idx] <= pc_q[29 -: TW];
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_q + 32'((accept && hit) ? 1 : 0);
            miss_cnt_q <= miss_cnt_q + 32'((accept && !hit) ? 1 : 0);
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench for icache_ctrl (default geometry DEPTH=128, LINE_WORDS=4).
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, if_req, flush, mem_ack;
    logic [31:0] if_pc, mem_rdata;
    logic        if_ready, if_valid, mem_req;
    logic [31:0] if_ins, mem_addr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_chk = 0, n_pass = 0, cyc = 0, stall = 0;
    logic [31:0] exp_q[$], beats[$];
    int vcyc[$];

    icache_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_pc_i     (if_pc),
        .if_ready_o  (if_ready),
        .if_valid_o  (if_valid),
        .if_ins_o    (if_ins),
        .flush_i     (flush),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Memory responder: acks after `stall` wait cycles, and acks spuriously while idle.
    initial begin
        int sn = 0;
        logic prev_req = 1'b0, prev_ack = 1'b0;
        logic [31:0] prev_addr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (prev_req && !prev_ack) begin
                    chk("addr_stable", mem_addr, prev_addr);
                    chk("ready_low_refill", {31'b0, if_ready}, 32'd0);
                end
                if (sn < stall) begin
                    mem_ack = 1'b0;
                    sn++;
                end else begin
                    mem_ack = 1'b1;
                    mem_rdata = mdata(mem_addr);
                    beats.push_back(mem_addr);
                    sn = 0;
                end
            end else begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                sn = 0;
            end
            prev_req = mem_req;
            prev_ack = mem_ack && mem_req;
            prev_addr = mem_addr;
        end
    end

    // Monitor: every response pops the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n && if_valid) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: got if_ins %h with nothing outstanding", if_ins);
            end else begin
                chk("if_ins", if_ins, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] pc, output int waited);
        waited = 0;
        while (!if_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_timeout", {31'b0, waited >= 300}, 32'd0);
        if_req = 1'b1;
        if_pc = pc;
        exp_q.push_back(mdata({pc[31:2], 2'b00}));
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("resp_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_beats(input string name, input logic [31:0] base);
        chk({name, "_n"}, beats.size(), 32'd4);
        for (int i = 0; i < 4 && i < beats.size(); i++)
            chk({name, "_addr"}, beats[i], base + 32'(4 * i));
    endtask

    initial begin
        int w, acc, t;
        rst_n = 1'b0;
        if_req = 1'b0;
        if_pc = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_ins", if_ins, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss: line refilled from offset 0, response is word 0x10.
        beats.delete();
        vcyc.delete();
        issue(32'h10, w);
        acc = cyc;
        wait_done();
        chk_beats("cold", 32'h10);
        if (vcyc.size() == 1) chk("miss_latency", 32'(vcyc[0] - acc), 32'd5);
        else chk("miss_valid_count", vcyc.size(), 32'd1);

        // Hit stream: four back-to-back hits, no memory traffic, ready held high.
        beats.delete();
        vcyc.delete();
        for (int i = 0; i < 4; i++) begin
            issue(32'h10 + 32'(4 * i), w);
            chk("hit_ready", w, 32'd0);
        end
        wait_done();
        chk("hit_beats", beats.size(), 32'd0);
        chk("hit_valid_count", vcyc.size(), 32'd4);
        if (vcyc.size() == 4) chk("hit_back_to_back", 32'(vcyc[3] - vcyc[0]), 32'd3);

        // Conflict eviction at index 0.
        beats.delete();
        issue(32'h0, w);
        wait_done();
        issue(32'h200, w);
        wait_done();
        issue(32'h0, w);
        wait_done();
        chk("conflict_beats", beats.size(), 32'd12);
        if (beats.size() == 12) begin
            chk("conflict_evict", beats[4], 32'h200);
            chk("conflict_remiss", beats[8], 32'h0);
        end
        beats.delete();
        issue(32'h14, w);
        wait_done();
        chk("other_line_hit", beats.size(), 32'd0);

        // Flush in IDLE blocks the concurrent request, then the line refills.
        beats.delete();
        flush = 1'b1;
        if_req = 1'b1;
        if_pc = 32'h10;
        #1 chk("flush_ready", {31'b0, if_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        if_req = 1'b0;
        issue(32'h10, w);
        wait_done();
        chk_beats("flush_refill", 32'h10);

        // Flush during refill: response delivered, line left invalid.
        beats.delete();
        issue(32'h40, w);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done();
        beats.delete();
        issue(32'h40, w);
        wait_done();
        chk_beats("flush_mid_refill", 32'h40);

        // Stalled memory: 5 idle cycles per beat.
        beats.delete();
        vcyc.delete();
        stall = 5;
        issue(32'h88, w);
        wait_done();
        stall = 0;
        repeat (3) @(negedge clk);
        chk_beats("stall", 32'h80);
        chk("stall_valid_once", vcyc.size(), 32'd1);

        // Reset after beat 1 drops mem_req asynchronously; refill restarts from beat 0.
        beats.delete();
        issue(32'hC4, w);
        t = 0;
        while (beats.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        chk("mem_req_before_rst", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_async_if_valid", {31'b0, if_valid}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef ICACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        beats.delete();
        issue(32'hC4, w);
        wait_done();
        chk_beats("post_rst_refill", 32'hC0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache controller for the MIPS fetch stage. It holds the tag and valid state and the data array, answers fetch requests in one cycle on a hit, and refills a whole line from backing memory on a miss over a word-wide request/acknowledge interface. It sits between the IF stage and the instruction memory/bus port.

## Interface

- DEPTH, 128: data array size in 32-bit words; power of two.
- LINE_WORDS, 4: words per line; power of two, 2..DEPTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_pc  in  32  byte address of the fetch; bits [1:0] are ignored.
- if_ready  out  1  controller can accept a request this cycle.
- if_valid  out  1  one-cycle pulse: if_ins is valid.
- if_ins  out  32  fetched instruction.
- flush  in  1  invalidate all lines.
- mem_req  out  1  refill beat request.
- mem_addr  out  32  word-aligned byte address of the current beat.
- mem_ack  in  1  beat accepted; mem_rdata valid this cycle.
- mem_rdata  in  32  refill data.

## Operation

- Address split: offset = if_pc[2 +: OFF_W], index = if_pc[2+OFF_W +: IDX_W], tag = if_pc[31 : 2+OFF_W+IDX_W]. OFF_W = clog2(LINE_WORDS), IDX_W = clog2(DEPTH/LINE_WORDS).
- A request is accepted when if_req && if_ready. On acceptance the controller captures if_pc and reads tag, valid and data combinationally.
- FSM states:
  - IDLE: if_ready = !flush. An accepted hit goes to IDLE, and if_valid and if_ins are registered for the next cycle. An accepted miss goes to REFILL with beat = 0.
  - REFILL: mem_req = 1 and mem_addr = {line base, beat, 2'b00}. Each mem_ack writes mem_rdata into word beat and increments beat. The ack on beat LINE_WORDS-1 moves the FSM to RESP.
  - RESP: the controller writes the tag, sets valid (unless a flush is pending), drives if_valid = 1 with if_ins = the requested word, and returns to IDLE.
- Refill order is linear from offset 0. There is no critical-word-first.
- flush clears every valid bit in one cycle.
  - If flush arrives in REFILL or RESP, a pending-flush flag is set. The refill still completes and its response is delivered, but that line is not marked valid.
  - flush in IDLE blocks acceptance that cycle.
- mem_ack while mem_req is low is ignored.
- The controller supports only one outstanding request. There is no hit-under-miss.

## Timing

- Reset values: state = IDLE, all valid bits = 0, if_valid = 0, if_ins = 0, mem_req = 0, mem_addr = 0, beat = 0, and the pending-flush flag = 0. The tag and data arrays are not reset.
- Hit latency: accept in cycle N, if_valid at N+1. Back-to-back hits sustain 1 fetch per cycle.
- Miss latency: accept in cycle N, mem_req from N+1. If every beat is acked in the cycle it is requested, if_valid arrives at N+LINE_WORDS+2.
- if_ready is low from N+1 until the cycle after RESP.
- mem_req stays high across all beats. mem_addr is stable until mem_ack, then advances on the next cycle.
- Reset asserted mid-refill immediately drops mem_req and if_valid. The partially written line stays invalid.

## Configuration

- ICACHE_STATS_EN
  - Defined: adds output ports hit_cnt[31:0] and miss_cnt[31:0]. Each counts accepted hits or misses, wraps at 2^32, and resets to 0. flush does not clear them.
  - Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure

- icache_pkg holds:
  - the FSM state enum (IDLE, REFILL, RESP);
  - width helper functions and constants (OFF_W, IDX_W, TAG_W derived via $clog2);
  - a packed struct for the {tag, index, offset} address split.
- Sub-module icache_data_ram: a DEPTH x 32 array with a combinational read port and a synchronous write port. The controller owns the tags, valid bits and FSM.

## Test plan

- Cold miss: after reset, request pc 0x0000_0010. Expect mem_addr 0x10, 0x14, 0x18, 0x1C in order, then if_valid with if_ins = the word returned for 0x10. Expect no beats for 0x00–0x0C.
- Hit stream: after the fill above, request 0x10, 0x14, 0x18, 0x1C on consecutive cycles. Expect 4 consecutive if_valid pulses with matching data, mem_req never asserted, and if_ready held high.
- Conflict eviction: fill 0x0000_0000, then request 0x0000_0200 (same index at DEPTH=128). Expect a refill. A following request to 0x0 misses again.
- Flush: fill a line and assert flush for one cycle. The next request to the same pc must refill. flush raised during a REFILL beat: the response is delivered and the line is still invalid afterwards.
- Stalled memory: hold mem_ack low 5 cycles per beat. mem_addr must stay stable and if_ready stay low throughout. if_valid arrives exactly once.
- Reset mid-refill: drop rst_n after beat 1. mem_req falls without waiting for clk. After release, the same pc misses and refills from beat 0. With ICACHE_STATS_EN, hit_cnt and miss_cnt read 0.
